uart_rx: RTL

- Serial UART receiver; the receive end of the uart_txd -> uart_rxd link in top.
- Samples the asynchronous uart_rxd line and deserialises 8N1 frames, LSB first.
- Presents each received byte to the core on a valid/ready handshake, with a one-byte holding register.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_defs.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, frame width, default bit period
// and the even-parity helper, used by the receiver and the transmitter.
package uart_defs;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 139;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage synchroniser for asynchronous single-bit inputs (rxd, gpio, ...).
// All stages reset to RESET_VAL so an idle-high line reads as idle from reset.
module sync_2ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames LSB first into a one-byte valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TICK = CW'(CLKS_PER_BIT - 1);

    // Handshake: a byte is transferred on a rising edge where rx_valid & rx_ready;
    // rx_data is stable while rx_valid=1 and rx_ready is ignored while rx_valid=0.

    logic          rxd_s;
    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          brk;
    logic          done;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    assign busy = (state != ST_IDLE);

    // Baud counter free-runs inside a state and reloads to 0 on every state
    // entry and after each full-bit strobe, keeping samples at mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            brk       <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            baud_cnt  <= baud_cnt + CW'(1);
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rxd_s) state <= ST_START;
                end
                ST_START: begin
                    if (baud_cnt == HALF_TICK) begin
                        baud_cnt <= '0;
                        state    <= rxd_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == FULL_TICK) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_cnt == FULL_TICK) begin
                        baud_cnt <= '0;
                        par_bad  <= rxd_s ^ even_parity(shift_reg);
                        state    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (brk) begin
                        // Line held low past the stop bit: wait for it to return high.
                        baud_cnt <= '0;
                        if (rxd_s) begin
                            brk   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (baud_cnt == FULL_TICK) begin
                        baud_cnt <= '0;
                        if (rxd_s) begin
                            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) parity_err <= 1'b1;
                            else         done       <= 1'b1;
`else
                            done <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: a completion while full is an overrun unless the old
    // byte is being accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
